// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Multiply (op 4'b1000) is done as N shift-and-add passes through the ALU adder.
module alu_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_y,
    output logic         rsp_flg,
    output logic [3:0]   alu_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_y,
    input  logic         alu_flg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_ADD = 4'b0000;

    logic [1:0]    state_r;
    logic          ptr_r;
    logic [3:0]    op_r;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  acc_r;
    logic [CW-1:0] iter_r;
    logic          rsp_id_r;
    logic [N-1:0]  rsp_y_r;
    logic          rsp_flg_r;

    logic          sel_s;
    logic          ready0_s;
    logic          ready1_s;
    logic          accept_s;
    logic [3:0]    req_op_s;
    logic [N-1:0]  req_a_s;
    logic [N-1:0]  req_b_s;
    logic [N-1:0]  shift_s;
    logic          mul_bit_s;
    logic [3:0]    alu_op_s;
    logic [N-1:0]  alu_a_s;
    logic [N-1:0]  alu_b_s;

    // Round-robin grant; ready is gated by rst so nothing is offered during reset.
    always_comb begin
        sel_s = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_s = ptr_r;
        end else if (req1_valid) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        ready0_s = !rst && (state_r == IDLE) && req0_valid && !sel_s;
        ready1_s = !rst && (state_r == IDLE) && req1_valid && sel_s;
        accept_s = ready0_s || ready1_s;
        req_op_s = sel_s ? req1_op : req0_op;
        req_a_s  = sel_s ? req1_a  : req0_a;
        req_b_s  = sel_s ? req1_b  : req0_b;
    end

    // ALU operand steering: pass-through in EXEC, accumulate partial products in MUL.
    always_comb begin
        shift_s   = a_r << iter_r;
        mul_bit_s = b_r[iter_r];
        alu_op_s  = 4'b0000;
        alu_a_s   = {N{1'b0}};
        alu_b_s   = {N{1'b0}};
        case (state_r)
            EXEC: begin
                alu_op_s = op_r;
                alu_a_s  = a_r;
                alu_b_s  = b_r;
            end
            MUL: begin
                alu_op_s = OP_ADD;
                alu_a_s  = acc_r;
                alu_b_s  = shift_s;
            end
            default: begin
                alu_op_s = 4'b0000;
                alu_a_s  = {N{1'b0}};
                alu_b_s  = {N{1'b0}};
            end
        endcase
    end

    // Control FSM and operand/result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= 1'b0;
            op_r      <= 4'b0000;
            a_r       <= {N{1'b0}};
            b_r       <= {N{1'b0}};
            acc_r     <= {N{1'b0}};
            iter_r    <= {CW{1'b0}};
            rsp_id_r  <= 1'b0;
            rsp_y_r   <= {N{1'b0}};
            rsp_flg_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r     <= req_op_s;
                        a_r      <= req_a_s;
                        b_r      <= req_b_s;
                        rsp_id_r <= sel_s;
                        ptr_r    <= !sel_s;
                        acc_r    <= {N{1'b0}};
                        iter_r   <= {CW{1'b0}};
                        state_r  <= (req_op_s == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_r   <= alu_y;
                    rsp_flg_r <= alu_flg;
                    state_r   <= RESP;
                end
                MUL: begin
                    if (mul_bit_s) begin
                        acc_r <= alu_y;
                    end
                    if (iter_r == LAST_ITER) begin
                        rsp_y_r   <= mul_bit_s ? alu_y : acc_r;
                        rsp_flg_r <= 1'b0;
                        state_r   <= RESP;
                    end else begin
                        iter_r <= iter_r + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign rsp_valid  = (state_r == RESP);
    assign rsp_id     = rsp_id_r;
    assign rsp_y      = rsp_y_r;
    assign rsp_flg    = rsp_flg_r;
    assign alu_op     = alu_op_s;
    assign alu_a      = alu_a_s;
    assign alu_b      = alu_b_s;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle,
// directed scenarios with hand-computed literals, then randomized traffic.
module tb_alu_arbiter;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_flg;
    logic [N-1:0] rsp_y;
    logic [3:0]   alu_op;
    logic [N-1:0] alu_a, alu_b, alu_y;
    logic         alu_flg;

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flg(rsp_flg),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_flg(alu_flg)
    );

    // External ALU: {flag, result}
    function automatic logic [N:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] r;
        case (op)
            4'd0: r = {1'b0, a} + {1'b0, b};
            4'd1: r = {1'b0, a} - {1'b0, b};
            4'd2: r = {1'b0, a & b};
            4'd3: r = {1'b0, a | b};
            default: begin
                r[N-1:0] = a ^ b ^ {op, op};
                r[N]     = ^r[N-1:0];
            end
        endcase
        return r;
    endfunction

    assign {alu_flg, alu_y} = alu_fn(alu_op, alu_a, alu_b);

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Staged stimulus, applied at the next falling edge by step()
    bit s_rst, s_v0, s_v1, s_rr;
    logic [3:0]   s_op0, s_op1;
    logic [N-1:0] s_a0, s_b0, s_a1, s_b1;

    // Transaction model: one job in flight, m_left cycles before its response shows
    bit           m_pend, m_mul, m_flg, m_id, m_p, acc_flag;
    int           m_left;
    logic [3:0]   m_op;
    logic [N-1:0] m_a, m_b, m_y;

    task automatic step();
        bit win;
        int i;
        logic [3:0]   eo;
        logic [N-1:0] ea, eb;
        @(negedge clk);
        rst = s_rst; rsp_ready = s_rr;
        req0_valid = s_v0; req0_op = s_op0; req0_a = s_a0; req0_b = s_b0;
        req1_valid = s_v1; req1_op = s_op1; req1_a = s_a1; req1_b = s_b1;
        #1;
        acc_flag = 1'b0;
        win = (s_v0 && s_v1) ? m_p : s_v1;
        if (s_rst) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_y", rsp_y, 0);
            chk("rst_rsp_flg", rsp_flg, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
        end else begin
            chk("ready0", req0_ready, !m_pend && s_v0 && !win);
            chk("ready1", req1_ready, !m_pend && s_v1 && win);
            chk("rsp_valid", rsp_valid, m_pend && m_left == 0);
            if (m_pend && m_left == 0) begin
                chk("rsp_y", rsp_y, m_y);
                chk("rsp_flg", rsp_flg, m_flg);
                chk("rsp_id", rsp_id, m_id);
            end
            eo = 4'd0; ea = '0; eb = '0;
            if (m_pend && m_left > 0) begin
                if (m_mul) begin
                    i  = N - m_left;
                    ea = N'(int'(m_a) * (int'(m_b) & ((1 << i) - 1)));
                    eb = N'(int'(m_a) << i);
                end else begin
                    eo = m_op; ea = m_a; eb = m_b;
                end
            end
            chk("alu_op", alu_op, eo);
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
        end
        if (s_rst) begin
            m_pend = 1'b0; m_p = 1'b0;
        end else if (!m_pend) begin
            if (s_v0 || s_v1) begin
                acc_flag = 1'b1;
                m_pend = 1'b1;
                m_id   = win;
                m_op   = win ? s_op1 : s_op0;
                m_a    = win ? s_a1 : s_a0;
                m_b    = win ? s_b1 : s_b0;
                m_mul  = (m_op == 4'b1000);
                m_left = m_mul ? N : 1;
                if (m_mul) begin
                    m_y = N'(int'(m_a) * int'(m_b)); m_flg = 1'b0;
                end else begin
                    {m_flg, m_y} = alu_fn(m_op, m_a, m_b);
                end
                m_p = !win;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (s_rr) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic do_reset();
        s_rst = 1'b1; s_v0 = 1'b0; s_v1 = 1'b0;
        step(); step();
        s_rst = 1'b0;
    endtask

    int lat;
    int n_ids;
    bit ids [4];
    logic [N-1:0] hold_y;
    bit hold_id, hold_flg;

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
        s_rr = 1'b1; s_op0 = '0; s_op1 = '0; s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0;
        m_pend = 1'b0; m_p = 1'b0; m_left = 0;
        do_reset();

        // Plain add: response two cycles after accept
        s_v0 = 1'b1; s_op0 = 4'b0000; s_a0 = 8'd100; s_b0 = 8'd27; s_rr = 1'b1;
        step();
        chk("add_accept", acc_flag, 1);
        s_v0 = 1'b0;
        step();
        chk("add_t1_valid", rsp_valid, 0);
        step();
        chk("add_t2_valid", rsp_valid, 1);
        chk("add_y", rsp_y, 8'd127);
        chk("add_id", rsp_id, 0);
        chk("add_flg", rsp_flg, 0);
        step();

        // Both requesting continuously: grants alternate starting with 0
        do_reset();
        s_v0 = 1'b1; s_v1 = 1'b1; s_op0 = 4'd3; s_op1 = 4'd2; s_rr = 1'b1;
        n_ids = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (rsp_valid && n_ids < 4) begin
                ids[n_ids] = rsp_id;
                n_ids++;
            end
        end
        chk("rr_count", n_ids, 4);
        chk("rr_seq", {ids[0], ids[1], ids[2], ids[3]}, 4'b0101);
        s_v0 = 1'b0; s_v1 = 1'b0;
        while (m_pend) step();

        // Multiply from requester 1
        for (int t = 0; t < 2; t++) begin
            s_v1 = 1'b1; s_op1 = 4'b1000;
            s_a1 = (t == 0) ? 8'd13 : 8'd20;
            s_b1 = (t == 0) ? 8'd11 : 8'd20;
            step();
            chk("mul_accept", acc_flag, 1);
            s_v1 = 1'b0;
            lat = 0;
            do begin
                step();
                lat++;
            end while (!rsp_valid && lat < 20);
            chk("mul_latency", lat, 9);
            chk("mul_y", rsp_y, (t == 0) ? 8'h8F : 8'h90);
            chk("mul_flg", rsp_flg, 0);
            chk("mul_id", rsp_id, 1);
            step();
        end

        // Back-pressure: response held while rsp_ready stays low
        s_v0 = 1'b1; s_op0 = 4'd1; s_a0 = 8'd5; s_b0 = 8'd9;
        step();
        s_v1 = 1'b1; s_op1 = 4'd0; s_rr = 1'b0;
        step(); step();
        chk("bp_valid0", rsp_valid, 1);
        chk("bp_y0", rsp_y, 8'hFC);
        chk("bp_flg0", rsp_flg, 1);
        hold_y = rsp_y; hold_id = rsp_id; hold_flg = rsp_flg;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_hold", {rsp_y, rsp_id, rsp_flg}, {hold_y, hold_id, hold_flg});
            chk("bp_ready", {req0_ready, req1_ready}, 2'b00);
        end
        s_rr = 1'b1;
        step();
        chk("bp_hs_ready", {req0_ready, req1_ready}, 2'b00);
        step();
        chk("bp_idle_valid", rsp_valid, 0);
        chk("bp_idle_ready", req0_ready | req1_ready, 1);
        s_v0 = 1'b0; s_v1 = 1'b0;
        while (m_pend) step();

        // Reset during MUL iteration 3 aborts the job
        s_v0 = 1'b1; s_op0 = 4'b1000; s_a0 = 8'd7; s_b0 = 8'd9;
        step();
        s_v0 = 1'b0;
        step(); step(); step();
        s_rst = 1'b1;
        step();
        chk("abort_alu", {alu_op, alu_a, alu_b}, 0);
        s_rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("abort_no_rsp", rsp_valid, 0);
        end

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            s_rst = ($urandom_range(0, 99) == 0);
            s_v0  = ($urandom_range(0, 2) != 0);
            s_v1  = ($urandom_range(0, 2) != 0);
            s_rr  = ($urandom_range(0, 3) != 0);
            s_op0 = ($urandom_range(0, 3) == 0) ? 4'b1000 : 4'($urandom);
            s_op1 = ($urandom_range(0, 3) == 0) ? 4'b1000 : 4'($urandom);
            s_a0 = N'($urandom); s_b0 = N'($urandom);
            s_a1 = N'($urandom); s_b1 = N'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
